// File: rtl/lsu_byte_serial.sv
// ============================================================================
// Module     : lsu_byte_serial
// Description: Load/store unit that serialises byte/half/word accesses into
//              little-endian single-byte memory cycles.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_byte_serial #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [7:0]               mem_wd,
  output logic                     mem_we,
  input  logic [7:0]               mem_rd
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;
  localparam logic [1:0] c_SIZE_ILL  = 2'b11;

  state_t                   r_state;
  state_t                   w_state_next;

  logic                     r_we;
  logic [1:0]               r_size;
  logic                     r_unsigned;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     r_err;
  logic [1:0]               r_k;
  logic [DATA_WIDTH-1:0]    r_buf;

  logic                     w_req_err;
  logic                     w_accept;
  logic [1:0]               w_last_k;
  logic                     w_xfer_done;
  logic [4:0]               w_lane_lsb;
  logic                     w_sign_en;
  logic [DATA_WIDTH-1:0]    w_load_ext;

  assign w_req_err = (req_size == c_SIZE_ILL)
                   | ((req_size == c_SIZE_HALF) & req_addr[0])
                   | ((req_size == c_SIZE_WORD) & (req_addr[1:0] != 2'b00));

  assign w_accept    = (r_state == ST_IDLE) & req_valid;
  assign w_lane_lsb  = {r_k, 3'b000};
  assign w_xfer_done = (r_k == w_last_k);

  // Index of the final byte lane (N-1) for the captured size.
  always_comb begin
    w_last_k = 2'd3;
    case (r_size)
      c_SIZE_BYTE: w_last_k = 2'd0;
      c_SIZE_HALF: w_last_k = 2'd1;
      default:     w_last_k = 2'd3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_next = w_req_err ? ST_RESP : ST_XFER;
        end
      end
      ST_XFER: begin
        if (w_xfer_done) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_k        <= 2'd0;
      r_buf      <= '0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
      r_err      <= w_req_err;
      r_k        <= 2'd0;
      r_buf      <= '0;
    end else if (r_state == ST_XFER) begin
      if (!r_we) begin
        r_buf[w_lane_lsb +: 8] <= mem_rd;
      end
      if (!w_xfer_done) begin
        r_k <= r_k + 2'd1;
      end
    end
  end

  assign w_sign_en = ~r_unsigned;

  always_comb begin
    w_load_ext = r_buf;
    case (r_size)
      c_SIZE_BYTE: w_load_ext = {{24{w_sign_en & r_buf[7]}}, r_buf[7:0]};
      c_SIZE_HALF: w_load_ext = {{16{w_sign_en & r_buf[15]}}, r_buf[15:0]};
      default:     w_load_ext = r_buf;
    endcase
  end

  // Memory port is idle outside XFER so rejected requests never reach memory.
  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_a      = '0;
    mem_wd     = 8'h00;
    mem_we     = 1'b0;
    case (r_state)
      ST_XFER: begin
        mem_a  = r_addr + {{(ADDRESS_WIDTH-2){1'b0}}, r_k};
        mem_wd = r_wdata[w_lane_lsb +: 8];
        mem_we = r_we;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        if (!r_we && !r_err) begin
          resp_rdata = w_load_ext;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_byte_serial.sv
// ============================================================================
// Module     : tb_lsu_byte_serial
// Description: Directed self-checking bench for lsu_byte_serial with a
//              byte-wide memory model.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_byte_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic [7:0]  mem_wd;
  logic        mem_we;
  logic [7:0]  mem_rd;

  logic [7:0]  mem [0:4095];

  int errors = 0;
  int checks = 0;

  lsu_byte_serial #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_we       (mem_we),
    .mem_rd       (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[11:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[11:0]] <= mem_wd;
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int c;
    int wecnt;
    @(negedge clk);
    check($sformatf("v%0d_ready_before", i), 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = vecs[i].we;
    req_size     = vecs[i].size;
    req_unsigned = vecs[i].uns;
    req_addr     = vecs[i].addr;
    req_wdata    = vecs[i].wdata;
    @(posedge clk); #1;
    // Scramble inputs after accept; they must not influence the transfer.
    req_valid    = 1'b0;
    req_we       = ~vecs[i].we;
    req_size     = 2'b11;
    req_unsigned = ~vecs[i].uns;
    req_addr     = 32'h0000_0FF0;
    req_wdata    = 32'h0BAD_F00D;
    c = 1;
    wecnt = 0;
    while (!resp_valid && c < 12) begin
      if (mem_we) wecnt++;
      @(posedge clk); #1;
      c++;
    end
    check($sformatf("v%0d_latency", i), resp_valid ? 32'(c) : 32'd0, 32'(vecs[i].exp_lat));
    check($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
    check($sformatf("v%0d_err", i), 32'(resp_err), 32'(vecs[i].exp_err));
    check($sformatf("v%0d_we_cycles", i), 32'(wecnt), 32'(vecs[i].exp_we));
    @(posedge clk); #1;
    check($sformatf("v%0d_pulse_end", i), {30'd0, resp_valid, req_ready}, 32'd1);
    check($sformatf("v%0d_rdata_idle", i), resp_rdata, 32'h0);
  endtask

  initial begin
    int c;
    int low_cnt;

    //             we    size   uns   addr        wdata          exp_rdata      err  lat we
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h00000000, 1'b0, 5, 4};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h00000000, 32'hDEADBEEF, 1'b0, 5, 0};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h200, 32'h12345680, 32'h00000000, 1'b0, 2, 1};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h201, 32'hFFFFFF7F, 32'h00000000, 1'b0, 2, 1};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h200, 32'h00000000, 32'hFFFFFF80, 1'b0, 2, 0};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h200, 32'h00000000, 32'h00000080, 1'b0, 2, 0};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h200, 32'h00000000, 32'h00007F80, 1'b0, 3, 0};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h200, 32'h00000000, 32'h00007F80, 1'b0, 3, 0};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h103, 32'hFFFFFF55, 32'h00000000, 1'b0, 2, 1};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h00000000, 32'h55ADBEEF, 1'b0, 5, 0};
    vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h201, 32'h00000000, 32'h00000000, 1'b1, 1, 0};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h00000000, 32'h00000000, 1'b1, 1, 0};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h100, 32'h00000000, 32'h00000000, 1'b1, 1, 0};
    vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h201, 32'h0000AAAA, 32'h00000000, 1'b1, 1, 0};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h300, 32'hAABBCCDD, 32'h00000000, 1'b0, 5, 4};
    vecs[15] = '{1'b0, 2'b01, 1'b0, 32'h302, 32'h00000000, 32'hFFFFAABB, 1'b0, 3, 0};
    vecs[16] = '{1'b0, 2'b01, 1'b1, 32'h302, 32'h00000000, 32'h0000AABB, 1'b0, 3, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp", {29'd0, resp_valid, resp_err, mem_we}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wd", 32'(mem_wd), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    check("mem_100", 32'(mem[12'h100]), 32'hEF);
    check("mem_101", 32'(mem[12'h101]), 32'hBE);
    check("mem_102", 32'(mem[12'h102]), 32'hAD);
    check("mem_103", 32'(mem[12'h103]), 32'h55);
    check("mem_200", 32'(mem[12'h200]), 32'h80);
    check("mem_201", 32'(mem[12'h201]), 32'h7F);

    // Reset during the 3rd XFER cycle of a word store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h300; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_xfer_we", 32'(mem_we), 32'd1);
    check("abort_in_xfer_a", mem_a, 32'h302);
    rst = 1'b1;
    #1;
    check("abort_we_drop", 32'(mem_we), 32'd0);
    check("abort_a_zero", mem_a, 32'h0);
    check("abort_ready", 32'(req_ready), 32'd1);
    // Request presented while reset is high must be ignored
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h303; req_wdata = 32'h99;
    low_cnt = 0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      if (resp_valid || !req_ready || mem_we) low_cnt++;
    end
    check("abort_rst_quiet", 32'(low_cnt), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    low_cnt = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (resp_valid || !req_ready) low_cnt++;
    end
    check("abort_no_resp", 32'(low_cnt), 32'd0);
    check("abort_mem_300", 32'(mem[12'h300]), 32'h44);
    check("abort_mem_301", 32'(mem[12'h301]), 32'h33);
    check("abort_mem_302", 32'(mem[12'h302]), 32'hBB);
    check("abort_mem_303", 32'(mem[12'h303]), 32'hAA);

    // req_valid held high, request fields changed mid-transfer
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h0;
    @(posedge clk); #1;
    c = 1;
    low_cnt = 0;
    while (!resp_valid && c < 12) begin
      if (!req_ready) low_cnt++;
      if (c == 2) begin
        req_addr = 32'h200;
        req_size = 2'b00;
      end
      @(posedge clk); #1;
      c++;
    end
    if (!req_ready) low_cnt++;
    check("hold_latency", resp_valid ? 32'(c) : 32'd0, 32'd5);
    check("hold_rdata", resp_rdata, 32'h55ADBEEF);
    check("hold_ready_low", 32'(low_cnt), 32'd5);
    @(posedge clk); #1;
    check("hold_idle_ready", {30'd0, req_ready, resp_valid}, 32'd2);
    @(posedge clk); #1;
    check("hold_second_accept", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("hold_second_valid", 32'(resp_valid), 32'd1);
    check("hold_second_rdata", resp_rdata, 32'hFFFFFF80);
    @(posedge clk); #1;
    check("hold_end_ready", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
